// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: FSM encoding and bus-level constants
// shared by the I2C register target and its line synchronizer.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADDR,
    ST_DEV_ACK,
    ST_SUBADDR,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h39;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizers for SCL/SDA plus
// edge, START and STOP detection on the synchronized lines.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] r_scl_ff;
  logic [1:0] r_sda_ff;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       w_scl;
  logic       w_sda;

  // Synchronize both lines and keep one-cycle history.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scl_ff <= 2'b11;
      r_sda_ff <= 2'b11;
      r_scl_d  <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_ff <= {r_scl_ff[0], i_scl};
      r_sda_ff <= {r_sda_ff[0], i_sda};
      r_scl_d  <= r_scl_ff[1];
      r_sda_d  <= r_sda_ff[1];
    end
  end

  assign w_scl = r_scl_ff[1];
  assign w_sda = r_sda_ff[1];

  assign sda_s     = w_sda;
  assign scl_rise  = w_scl & ~r_scl_d;
  assign scl_fall  = ~w_scl & r_scl_d;
  assign start_det = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign stop_det  = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: oversampled I2C target with a byte register file.
// Define I2C_TARGET_READ_EN to add register read-back over the bus.
module i2c_reg_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         REG_AW   = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              I2C_SCLK,
  inout  wire               I2C_SDAT,
  output logic              WR_STROBE,
  output logic [REG_AW-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  input  logic [REG_AW-1:0] REG_RADDR,
  output logic [7:0]        REG_RDATA,
  output logic              BUSY
);

  localparam int DEPTH = 2 ** REG_AW;

`ifdef I2C_TARGET_READ_EN
  localparam logic READ_OK = 1'b1;
`else
  localparam logic READ_OK = 1'b0;
`endif

  logic [7:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_state_n;
  logic [2:0]        r_bitcnt;
  logic [2:0]        w_bitcnt_n;
  logic [6:0]        r_shift;
  logic [6:0]        w_shift_n;
  logic [REG_AW-1:0] r_ptr;
  logic [REG_AW-1:0] w_ptr_n;
  logic              r_sda_oe;
  logic              w_oe_n;
  logic              r_ackph;
  logic              w_ackph_n;
  logic              r_busy;
  logic              w_busy_n;
  logic              r_strobe;
  logic [REG_AW-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic              w_we;

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_sda_s;
  logic [7:0] w_byte;
  logic w_last;

`ifdef I2C_TARGET_READ_EN
  logic       r_rw;
  logic       w_rw_n;
  logic [7:0] r_tx;
  logic [7:0] w_tx_n;
  logic [7:0] w_rd_byte;
  assign w_rd_byte = r_mem[r_ptr];
`endif

  i2c_line_sync u_sync (
    .i_clk     (iCLK),
    .i_rst_n   (iRST_N),
    .i_scl     (I2C_SCLK),
    .i_sda     (I2C_SDAT),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda_s)
  );

  assign w_byte = {r_shift, w_sda_s};
  assign w_last = w_scl_rise && (r_bitcnt == 3'd7);

  assign I2C_SDAT  = r_sda_oe ? ACK : 1'bz;
  assign WR_STROBE = r_strobe;
  assign WR_ADDR   = r_waddr;
  assign WR_DATA   = r_wdata;
  assign BUSY      = r_busy;
  assign REG_RDATA = r_mem[REG_RADDR];

  // Next-state, shifter, pointer and SDA drive decisions.
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_ptr_n    = r_ptr;
    w_oe_n     = r_sda_oe;
    w_ackph_n  = r_ackph;
    w_busy_n   = r_busy;
    w_we       = 1'b0;
`ifdef I2C_TARGET_READ_EN
    w_rw_n     = r_rw;
    w_tx_n     = r_tx;
`endif
    if (w_stop) begin
      w_state_n  = ST_IDLE;
      w_oe_n     = 1'b0;
      w_busy_n   = 1'b0;
      w_bitcnt_n = '0;
    end else if (w_start) begin
      w_state_n  = ST_DEVADDR;
      w_oe_n     = 1'b0;
      w_bitcnt_n = '0;
    end else begin
      unique case (r_state)
        ST_DEVADDR: if (w_scl_rise) begin
          w_shift_n  = w_byte[6:0];
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (w_last) begin
            if (w_byte[7:1] != DEV_ADDR) begin
              w_state_n = ST_IGNORE;
            end else if (w_sda_s && !READ_OK) begin
              w_state_n = ST_IGNORE;
            end else begin
              w_state_n = ST_DEV_ACK;
              w_ackph_n = 1'b0;
              w_busy_n  = 1'b1;
`ifdef I2C_TARGET_READ_EN
              w_rw_n    = w_sda_s;
`endif
            end
          end
        end
        ST_SUBADDR: if (w_scl_rise) begin
          w_shift_n  = w_byte[6:0];
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (w_last) begin
            w_state_n = ST_SUB_ACK;
            w_ackph_n = 1'b0;
            w_ptr_n   = REG_AW'(w_byte);
          end
        end
        ST_WDATA: if (w_scl_rise) begin
          w_shift_n  = w_byte[6:0];
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (w_last) begin
            w_state_n = ST_WDATA_ACK;
            w_ackph_n = 1'b0;
            w_we      = 1'b1;
            w_ptr_n   = r_ptr + REG_AW'(1);
          end
        end
        ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK:
          if (w_scl_fall) begin
            if (!r_ackph) begin
              w_ackph_n = 1'b1;
              w_oe_n    = 1'b1;
            end else begin
              w_ackph_n  = 1'b0;
              w_oe_n     = 1'b0;
              w_bitcnt_n = '0;
              if (r_state != ST_DEV_ACK) begin
                w_state_n = ST_WDATA;
`ifdef I2C_TARGET_READ_EN
              end else if (r_rw) begin
                w_state_n = ST_RDATA;
                w_oe_n    = ~w_rd_byte[7];
                w_tx_n    = {w_rd_byte[6:0], 1'b1};
`endif
              end else begin
                w_state_n = ST_SUBADDR;
              end
            end
          end
`ifdef I2C_TARGET_READ_EN
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_bitcnt_n = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_state_n = ST_RD_ACK;
              w_ackph_n = 1'b0;
              w_ptr_n   = r_ptr + REG_AW'(1);
            end
          end else if (w_scl_fall) begin
            w_oe_n = ~r_tx[7];
            w_tx_n = {r_tx[6:0], 1'b1};
          end
        end
        ST_RD_ACK: begin
          if (w_scl_fall) begin
            if (!r_ackph) begin
              w_oe_n    = 1'b0;
              w_ackph_n = 1'b1;
            end else if (r_bitcnt == 3'd1) begin
              w_state_n  = ST_RDATA;
              w_ackph_n  = 1'b0;
              w_bitcnt_n = '0;
              w_oe_n     = ~w_rd_byte[7];
              w_tx_n     = {w_rd_byte[6:0], 1'b1};
            end
          end else if (w_scl_rise && r_ackph) begin
            if (w_sda_s == NACK) begin
              w_state_n = ST_IGNORE;
            end else begin
              w_bitcnt_n = 3'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Register FSM state, datapath and write-port outputs.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sda_oe <= 1'b0;
      r_ackph  <= 1'b0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_ptr    <= w_ptr_n;
      r_sda_oe <= w_oe_n;
      r_ackph  <= w_ackph_n;
      r_busy   <= w_busy_n;
      r_strobe <= w_we;
      if (w_we) begin
        r_waddr <= r_ptr;
        r_wdata <= w_byte;
      end
    end
  end

`ifdef I2C_TARGET_READ_EN
  // Read-side direction flag and transmit shifter.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_rw <= 1'b0;
      r_tx <= 8'hFF;
    end else begin
      r_rw <= w_rw_n;
      r_tx <= w_tx_n;
    end
  end
`endif

  // Register file write port; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (iRST_N && w_we) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: bus-master driven checks of the I2C
// register target against a simple array/queue model.
module tb_i2c_reg_target;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] raddr = 8'h00;
  logic [7:0] rdata;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;
  int drv_cnt = 0;
  bit busy_seen = 1'b0;

  logic [7:0]  mdl_mem [256];
  logic [7:0]  tx_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] stb_q [$];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_reg_target dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda),
    .WR_STROBE (wr_stb),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data),
    .REG_RADDR (raddr),
    .REG_RDATA (rdata),
    .BUSY      (busy)
  );

  always @(negedge clk) begin
    if (wr_stb) stb_q.push_back({wr_addr, wr_data});
    if (sda === 1'b0 && !m_low) drv_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_start();
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      #Q m_low = ~b[i];
      #Q scl = 1'b1;
      #(2*Q) scl = 1'b0;
    end
  endtask

  task automatic get_ack(output bit ack);
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q ack = (sda === 1'b0);
    #Q scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    send_bits(b, 8);
    get_ack(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input bit nack);
    for (int i = 7; i >= 0; i--) begin
      #Q m_low = 1'b0;
      #Q scl = 1'b1;
      #Q b[i] = (sda !== 1'b0);
      #Q scl = 1'b0;
    end
    #Q m_low = ~nack;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  // Full write transaction: dev byte then every byte of tx_q.
  task automatic write_xfer(input logic [7:0] dev, output int n_ack);
    bit a;
    n_ack = 0;
    bus_start();
    send_byte(dev, a);
    n_ack += int'(a);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], a);
      n_ack += int'(a);
    end
    bus_stop();
    #Q;
  endtask

  // Model: tx_q[0] is the sub-address, the rest are data bytes
  // stored at consecutive addresses wrapping at 256.
  task automatic model_write();
    logic [7:0] p;
    exp_q.delete();
    p = tx_q[0];
    for (int i = 1; i < tx_q.size(); i++) begin
      exp_q.push_back({p, tx_q[i]});
      mdl_mem[p] = tx_q[i];
      p = p + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (wr_stb !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobe got %b want 0", wr_stb);
    end
    n_chk++;
    if (wr_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr got %h want 00", wr_addr);
    end
    n_chk++;
    if (wr_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data got %h want 00", wr_data);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_chk++;
    if (sda !== 1'b1) begin
      n_fail++; $display("FAIL reset_sda got %b want 1", sda);
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_write_basic();
    bit a0, a1, a2;
    stb_q.delete();
    bus_start();
    send_byte(8'h72, a0);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_on got %b want 1", busy);
    end
    send_byte(8'h98, a1);
    send_byte(8'h03, a2);
    bus_stop();
    #Q;
    mdl_mem[8'h98] = 8'h03;
    n_chk++;
    if ({a0, a1, a2} !== 3'b111) begin
      n_fail++; $display("FAIL basic_acks got %b want 111", {a0, a1, a2});
    end
    n_chk++;
    if (stb_q.size() != 1) begin
      n_fail++; $display("FAIL basic_nstb got %0d want 1", stb_q.size());
    end
    n_chk++;
    if (stb_q.size() < 1 || stb_q[0] !== 16'h9803) begin
      n_fail++; $display("FAIL basic_stb got %p want 9803", stb_q);
    end
    raddr = 8'h98;
    #1;
    n_chk++;
    if (rdata !== 8'h03) begin
      n_fail++; $display("FAIL basic_rdata got %h want 03", rdata);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_off got %b want 0", busy);
    end
  endtask

  task automatic test_bad_addr();
    int n_ack;
    stb_q.delete();
    drv_cnt = 0;
    busy_seen = 1'b0;
    tx_q = '{8'h98, 8'h03};
    write_xfer(8'h74, n_ack);
    n_chk++;
    if (n_ack != 0) begin
      n_fail++; $display("FAIL bad_acks got %0d want 0", n_ack);
    end
    n_chk++;
    if (drv_cnt != 0) begin
      n_fail++; $display("FAIL bad_drive got %0d want 0", drv_cnt);
    end
    n_chk++;
    if (stb_q.size() != 0) begin
      n_fail++; $display("FAIL bad_nstb got %0d want 0", stb_q.size());
    end
    n_chk++;
    if (busy_seen) begin
      n_fail++; $display("FAIL bad_busy got 1 want 0");
    end
  endtask

  task automatic test_wrap();
    int n_ack;
    stb_q.delete();
    tx_q = '{8'hFE, 8'hAA, 8'hBB, 8'hCC};
    model_write();
    write_xfer(8'h72, n_ack);
    n_chk++;
    if (n_ack != 5) begin
      n_fail++; $display("FAIL wrap_acks got %0d want 5", n_ack);
    end
    n_chk++;
    if (stb_q.size() != 3) begin
      n_fail++; $display("FAIL wrap_nstb got %0d want 3", stb_q.size());
    end
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= stb_q.size() || stb_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_stb%0d got %p want %h", i, stb_q, exp_q[i]);
      end
    end
    raddr = 8'h00;
    #1;
    n_chk++;
    if (rdata !== 8'hCC) begin
      n_fail++; $display("FAIL wrap_reg00 got %h want cc", rdata);
    end
  endtask

  task automatic test_random();
    int n_ack;
    int nd;
    for (int t = 0; t < 6; t++) begin
      stb_q.delete();
      tx_q.delete();
      nd = $urandom_range(1, 4);
      tx_q.push_back(8'($urandom));
      for (int k = 0; k < nd; k++) tx_q.push_back(8'($urandom));
      model_write();
      write_xfer(8'h72, n_ack);
      n_chk++;
      if (n_ack != nd + 2) begin
        n_fail++; $display("FAIL rnd%0d_acks got %0d want %0d", t, n_ack, nd + 2);
      end
      n_chk++;
      if (stb_q.size() != nd) begin
        n_fail++; $display("FAIL rnd%0d_nstb got %0d want %0d", t, stb_q.size(), nd);
      end
      foreach (exp_q[i]) begin
        n_chk++;
        if (i >= stb_q.size() || stb_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_stb%0d got %p want %h", t, i, stb_q, exp_q[i]);
        end
        raddr = exp_q[i][15:8];
        #1;
        n_chk++;
        if (rdata !== mdl_mem[raddr]) begin
          n_fail++;
          $display("FAIL rnd%0d_reg%h got %h want %h", t, raddr, rdata, mdl_mem[raddr]);
        end
      end
    end
  endtask

  task automatic test_partial_stop();
    int n_ack;
    bit a;
    tx_q = '{8'h20, 8'h5C};
    model_write();
    write_xfer(8'h72, n_ack);
    stb_q.delete();
    bus_start();
    send_byte(8'h72, a);
    send_byte(8'h20, a);
    send_bits(8'hFF, 3);
    bus_stop();
    #Q;
    n_chk++;
    if (stb_q.size() != 0) begin
      n_fail++; $display("FAIL partial_nstb got %0d want 0", stb_q.size());
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL partial_busy got %b want 0", busy);
    end
    raddr = 8'h20;
    #1;
    n_chk++;
    if (rdata !== 8'h5C) begin
      n_fail++; $display("FAIL partial_reg got %h want 5c", rdata);
    end
  endtask

  task automatic test_reset_mid();
    int n_ack;
    bit a;
    stb_q.delete();
    bus_start();
    send_byte(8'h72, a);
    send_byte(8'h10, a);
    send_bits(8'hF0, 4);
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (sda !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_bit5_sda got %b want 1", sda);
    end
    scl = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus_stop();
    bus_start();
    send_byte(8'h72, a);
    send_bits(8'h10, 8);
    m_low = 1'b0;
    #Q;
    n_chk++;
    if (sda !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ack_drv got %b want 0", sda);
    end
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (sda !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_ack_sda got %b want 1", sda);
    end
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus_stop();
    n_chk++;
    if (stb_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_nstb got %0d want 0", stb_q.size());
    end
    tx_q = '{8'h10, 8'h55};
    model_write();
    write_xfer(8'h72, n_ack);
    n_chk++;
    if (n_ack != 3) begin
      n_fail++; $display("FAIL rstmid_acks got %0d want 3", n_ack);
    end
    n_chk++;
    if (stb_q.size() != 1 || stb_q[0] !== 16'h1055) begin
      n_fail++; $display("FAIL rstmid_stb got %p want 1055", stb_q);
    end
    raddr = 8'h10;
    #1;
    n_chk++;
    if (rdata !== 8'h55) begin
      n_fail++; $display("FAIL rstmid_reg got %h want 55", rdata);
    end
  endtask

`ifdef I2C_TARGET_READ_EN
  task automatic test_read();
    int n_ack;
    bit a0, a1, a2;
    logic [7:0] b;
    logic [7:0] sub;
    tx_q = '{8'h98, 8'h03};
    model_write();
    write_xfer(8'h72, n_ack);
    bus_start();
    send_byte(8'h72, a0);
    send_byte(8'h98, a1);
    bus_start();
    send_byte(8'h73, a2);
    recv_byte(b, 1'b1);
    bus_stop();
    #Q;
    n_chk++;
    if ({a0, a1, a2} !== 3'b111) begin
      n_fail++; $display("FAIL read_acks got %b want 111", {a0, a1, a2});
    end
    n_chk++;
    if (b !== 8'h03) begin
      n_fail++; $display("FAIL read_byte got %h want 03", b);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL read_busy got %b want 0", busy);
    end
    sub = 8'($urandom);
    tx_q = '{sub, 8'($urandom), 8'($urandom), 8'($urandom)};
    model_write();
    write_xfer(8'h72, n_ack);
    bus_start();
    send_byte(8'h72, a0);
    send_byte(sub, a1);
    bus_start();
    send_byte(8'h73, a2);
    for (int k = 0; k < 3; k++) begin
      recv_byte(b, k == 2);
      n_chk++;
      if (b !== mdl_mem[8'(sub + k)]) begin
        n_fail++;
        $display("FAIL burst_rd%0d got %h want %h", k, b, mdl_mem[8'(sub + k)]);
      end
    end
    bus_stop();
  endtask
`else
  task automatic test_read();
    bit a0, a1, a2;
    stb_q.delete();
    bus_start();
    send_byte(8'h72, a0);
    send_byte(8'h98, a1);
    bus_start();
    drv_cnt = 0;
    send_byte(8'h73, a2);
    bus_stop();
    #Q;
    n_chk++;
    if ({a0, a1, a2} !== 3'b110) begin
      n_fail++; $display("FAIL read_nack got %b want 110", {a0, a1, a2});
    end
    n_chk++;
    if (drv_cnt != 0) begin
      n_fail++; $display("FAIL read_drive got %0d want 0", drv_cnt);
    end
    n_chk++;
    if (stb_q.size() != 0) begin
      n_fail++; $display("FAIL read_nstb got %0d want 0", stb_q.size());
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL read_busy got %b want 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_bad_addr();
    test_wrap();
    test_random();
    test_partial_stop();
    test_reset_mid();
    test_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h39, 7-bit device address (write byte 8'h72, read byte 8'h73).
REQ-002 Parameter REG_AW, default 8, sub-address width; register file depth is 2**REG_AW bytes.
REQ-003 Port iCLK input 1: sole clock; I2C_SCLK and I2C_SDAT are oversampled in this domain.
REQ-004 Port iRST_N input 1: reset, synchronous and active-low.
REQ-005 Port I2C_SCLK input 1: I2C clock driven by the bus master.
REQ-006 Port I2C_SDAT inout 1: open-drain data line; the block drives only 0 or Z.
REQ-007 Port WR_STROBE output 1: one-cycle pulse per accepted data byte.
REQ-008 Port WR_ADDR output REG_AW: sub-address of the accepted byte, valid with WR_STROBE.
REQ-009 Port WR_DATA output 8: accepted data byte, valid with WR_STROBE.
REQ-010 Port REG_RADDR input REG_AW: host-side asynchronous read address into the register file.
REQ-011 Port REG_RDATA output 8: register file contents at REG_RADDR, combinational.
REQ-012 Port BUSY output 1: high from an addressed START until STOP.

Function
REQ-013 SCL and SDA pass through two-flop synchronizers; all edge, START and STOP decisions use the synchronized values.
REQ-014 START = SDA falls while SCL high; STOP = SDA rises while SCL high; both are recognised in every state.
REQ-015 FSM states: IDLE, DEVADDR, DEV_ACK, SUBADDR, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
REQ-016 Bits are sampled MSB first on the synchronized SCL rising edge; a bit counter runs 0..7.
REQ-017 START in any state -> DEVADDR, bit counter cleared; repeated START keeps the sub-address pointer.
REQ-018 After 8 address bits: an address match -> DEV_ACK; a mismatch -> IGNORE until the next START or STOP, SDA released.
REQ-019 ACK: SDA is driven low from the SCL falling edge after bit 8 until the next SCL falling edge, then released.
REQ-020 DEV_ACK with R/W=0 -> SUBADDR; SUB_ACK loads the pointer -> WDATA.
REQ-021 For each WDATA byte: the register file is written, WR_STROBE pulses once on the iCLK cycle after bit 8 is sampled, the byte is ACKed, the pointer increments modulo 2**REG_AW (0xFF wraps to 0x00), and the FSM returns to WDATA.
REQ-022 STOP -> IDLE, SDA released, BUSY low; a partial byte is discarded and produces no strobe.
REQ-023 The block never stretches SCL.

Reset
REQ-024 While iRST_N is low at a rising iCLK edge: FSM -> IDLE, SDA released (Z), WR_STROBE=0, WR_ADDR=0, WR_DATA=0, BUSY=0, pointer=0, bit counter=0, synchronizer flops=1.
REQ-025 Register file contents are not reset (power-up value is undefined).
REQ-026 Reset mid-transaction releases SDA on the next edge; after reset the bus is ignored until a fresh START.

Configuration
REQ-027 Macro I2C_TARGET_READ_EN defined: an address match with R/W=1 is ACKed -> RDATA; reg[pointer] is shifted out MSB first, changing on SCL falling edges; the pointer increments after each byte; master ACK -> next byte, master NACK -> IGNORE.
REQ-028 Macro I2C_TARGET_READ_EN undefined: an address match with R/W=1 is NACKed -> IGNORE; the RDATA and RD_ACK logic is absent.

Structure
REQ-029 Package i2c_target_pkg holds the FSM state enum, the ACK/NACK bit constants, and the default DEV_ADDR.
REQ-030 Sub-module i2c_line_sync holds the synchronizers and emits scl_rise, scl_fall, start_det, stop_det and sda_s.
REQ-031 Register file is an inferred 2**REG_AW x 8 array inside i2c_reg_target.

Verification
REQ-032 Write sequence 72,98,03 + STOP -> three ACKs, one WR_STROBE with WR_ADDR=98 and WR_DATA=03; REG_RADDR=98 gives REG_RDATA=03.
REQ-033 Sequence 74,98,03 -> NACK on the address, SDA never driven, no WR_STROBE, BUSY stays 0.
REQ-034 Burst 72,FE,AA,BB,CC -> strobes at FE, FF, 00 (wrap-around); reg[00]=CC.
REQ-035 iRST_N low during the 5th bit of a data byte -> SDA=Z on the next edge, no strobe; a subsequent clean write of 72,10,55 succeeds.
REQ-036 With I2C_TARGET_READ_EN defined, after reg[98]=03: 72,98, repeated START, 73 -> 8'h03 returned, then master NACK + STOP -> IDLE; without the macro, the 73 byte is NACKed.
